// File: rtl/fp_division_seq.sv
// Sequential floating-point divider: radix-2 restoring division with round-to-nearest-even.
// Fixed latency of MAN_W+5 cycles from the accepting edge to done, specials included.
module fp_division_seq #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [EXP_W+MAN_W:0] in1,
    input  logic [EXP_W+MAN_W:0] in2,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] out,
    output logic                 div_by_zero,
    output logic                 invalid,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int unsigned W     = 1 + EXP_W + MAN_W;
    localparam int unsigned EW    = EXP_W + 2;
    localparam int unsigned ITERS = MAN_W + 3;
    localparam int unsigned CW    = $clog2(ITERS + 1);
    localparam logic [EW-1:0]    BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EXP_W-1:0] EMAX = '1;

    typedef enum logic [1:0] {StIdle, StLoad, StDiv, StRound} state_e;

    state_e                state_q, state_d;
    logic [W-1:0]          a_q, a_d, b_q, b_d;
    logic                  sign_q, sign_d;
    logic signed [EW-1:0]  exp_q, exp_d;
    logic [MAN_W+1:0]      rem_q, rem_d;
    logic [MAN_W:0]        dvs_q, dvs_d;
    // Holds fraction, guard and round bits; the integer bit is always 1 and is shifted out.
    logic [MAN_W+1:0]      quo_q, quo_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  spec_q, spec_d, spec_dz_q, spec_dz_d, spec_inv_q, spec_inv_d;
    logic [W-1:0]          spec_res_q, spec_res_d;
    logic [W-1:0]          out_q, out_d;
    logic                  done_q, done_d;
    logic                  dz_q, dz_d, inv_q, inv_d, ovf_q, ovf_d, udf_q, udf_d;

    // Operand unpacking and classification (subnormals count as zero)
    logic                  s1, s2;
    logic [EXP_W-1:0]      e1, e2;
    logic [MAN_W-1:0]      f1, f2;
    logic                  nan1, nan2, inf1, inf2, zero1, zero2;
    logic [MAN_W:0]        m1, m2;
    logic signed [EW-1:0]  exp_raw;

    assign {s1, e1, f1} = a_q;
    assign {s2, e2, f2} = b_q;
    assign nan1  = (e1 == EMAX) && (f1 != '0);
    assign nan2  = (e2 == EMAX) && (f2 != '0);
    assign inf1  = (e1 == EMAX) && (f1 == '0);
    assign inf2  = (e2 == EMAX) && (f2 == '0);
    assign zero1 = (e1 == '0);
    assign zero2 = (e2 == '0);
    assign m1    = {1'b1, f1};
    assign m2    = {1'b1, f2};
    assign exp_raw = $signed({2'b00, e1}) - $signed({2'b00, e2}) + $signed(BIAS);

    // One restoring-division step
    logic                  ge;
    logic [MAN_W:0]        diff;
    assign ge   = rem_q >= {1'b0, dvs_q};
    assign diff = ge ? (MAN_W+1)'(rem_q - {1'b0, dvs_q}) : rem_q[MAN_W:0];

    // Rounding: lsb = quo_q[2], guard = quo_q[1], round = quo_q[0], sticky = remainder != 0
    logic                  round_up;
    logic [MAN_W:0]        frac_rnd;
    logic signed [EW-1:0]  exp_fin;
    assign round_up = quo_q[1] & (quo_q[0] | (rem_q != '0) | quo_q[2]);
    assign frac_rnd = {1'b0, quo_q[MAN_W+1:2]} + (MAN_W+1)'(round_up);
    assign exp_fin  = exp_q + $signed({{(EW-1){1'b0}}, frac_rnd[MAN_W]});

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        spec_d     = spec_q;
        spec_dz_d  = spec_dz_q;
        spec_inv_d = spec_inv_q;
        spec_res_d = spec_res_q;
        out_d      = out_q;
        dz_d       = dz_q;
        inv_d      = inv_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A start in the done cycle is dropped
                if (start && !done_q) begin
                    a_d     = in1;
                    b_d     = in2;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                sign_d = s1 ^ s2;
                cnt_d  = '0;
                quo_d  = '0;
                dvs_d  = m2;
                // Pre-shift keeps the quotient in [1,2)
                if (m1 < m2) begin
                    rem_d = {m1, 1'b0};
                    exp_d = exp_raw - EW'(1);
                end else begin
                    rem_d = {1'b0, m1};
                    exp_d = exp_raw;
                end
                spec_d     = 1'b1;
                spec_dz_d  = 1'b0;
                spec_inv_d = 1'b0;
                if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
                    spec_res_d = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
                    spec_inv_d = 1'b1;
                end else if (zero2 && !inf1) begin
                    spec_res_d = {s1 ^ s2, EMAX, {MAN_W{1'b0}}};
                    spec_dz_d  = 1'b1;
                end else if (inf1) begin
                    spec_res_d = {s1 ^ s2, EMAX, {MAN_W{1'b0}}};
                end else if (zero1 || inf2) begin
                    spec_res_d = {s1 ^ s2, {(W-1){1'b0}}};
                end else begin
                    spec_d     = 1'b0;
                    spec_res_d = '0;
                end
                state_d = StDiv;
            end
            StDiv: begin
                rem_d = {diff, 1'b0};
                quo_d = {quo_q[MAN_W:0], ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITERS - 1)) begin
                    state_d = StRound;
                end
            end
            StRound: begin
                done_d  = 1'b1;
                state_d = StIdle;
                dz_d    = 1'b0;
                inv_d   = 1'b0;
                ovf_d   = 1'b0;
                udf_d   = 1'b0;
                if (spec_q) begin
                    out_d = spec_res_q;
                    dz_d  = spec_dz_q;
                    inv_d = spec_inv_q;
                end else if (exp_fin >= $signed({2'b00, EMAX})) begin
                    out_d = {sign_q, EMAX, {MAN_W{1'b0}}};
                    ovf_d = 1'b1;
                end else if (exp_fin[EW-1] || (exp_fin == '0)) begin
                    out_d = {sign_q, {(W-1){1'b0}}};
                    udf_d = 1'b1;
                end else begin
                    // On a rounding carry the fraction bits are already zero
                    out_d = {sign_q, exp_fin[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            spec_q     <= 1'b0;
            spec_dz_q  <= 1'b0;
            spec_inv_q <= 1'b0;
            spec_res_q <= '0;
            out_q      <= '0;
            done_q     <= 1'b0;
            dz_q       <= 1'b0;
            inv_q      <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            spec_q     <= spec_d;
            spec_dz_q  <= spec_dz_d;
            spec_inv_q <= spec_inv_d;
            spec_res_q <= spec_res_d;
            out_q      <= out_d;
            done_q     <= done_d;
            dz_q       <= dz_d;
            inv_q      <= inv_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign out         = out_q;
    assign div_by_zero = dz_q;
    assign invalid     = inv_q;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

endmodule

// File: tb/tb_fp_division_seq.sv
// Self-checking bench for fp_division_seq: directed cases, random operands against an
// exact-arithmetic reference, overlap/reset behaviour and a half-precision instance.
module tb_fp_division_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] in1 = '0, in2 = '0, out;
    logic        busy, done, dz, inv, ovf, udf;

    logic        h_start = 1'b0;
    logic [15:0] h_in1 = '0, h_in2 = '0, h_out;
    logic        h_busy, h_done, h_dz, h_inv, h_ovf, h_udf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_division_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2),
        .busy(busy), .done(done), .out(out), .div_by_zero(dz), .invalid(inv),
        .overflow(ovf), .underflow(udf)
    );

    fp_division_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst_n(rst_n), .start(h_start), .in1(h_in1), .in2(h_in2),
        .busy(h_busy), .done(h_done), .out(h_out), .div_by_zero(h_dz), .invalid(h_inv),
        .overflow(h_ovf), .underflow(h_udf)
    );

    // Directed float32 cases: operands, result, flags {div_by_zero, invalid, overflow, underflow}
    localparam logic [31:0] DIR_A [7] = '{32'h41000000, 32'h3F800000, 32'h42CA0000,
        32'h3F800000, 32'h00000000, 32'h7F7FFFFF, 32'h00800000};
    localparam logic [31:0] DIR_B [7] = '{32'h40000000, 32'h40400000, 32'h40B00000,
        32'h00000000, 32'h00000000, 32'h3F000000, 32'h4B000000};
    localparam logic [31:0] DIR_O [7] = '{32'h40800000, 32'h3EAAAAAB, 32'h4192E8BA,
        32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h00000000};
    localparam logic [3:0]  DIR_F [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0100,
        4'b0010, 4'b0001};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: exact integer quotient with remainder-based round-to-nearest-even.
    // Returns {div_by_zero, invalid, overflow, underflow, result}.
    function automatic logic [35:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic   sg, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        int     e;
        longint ma, mb, num, q, r;
        sg     = a[31] ^ b[31];
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        a_zero = (a[30:23] == 0);
        b_zero = (b[30:23] == 0);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            return {4'b0100, 32'h7FC00000};
        if (b_zero && !a_inf) return {4'b1000, sg, 8'hFF, 23'h0};
        if (a_inf)            return {4'b0000, sg, 8'hFF, 23'h0};
        if (a_zero || b_inf)  return {4'b0000, sg, 31'h0};
        e   = int'(a[30:23]) - int'(b[30:23]) + 127;
        ma  = longint'({1'b1, a[22:0]});
        mb  = longint'({1'b1, b[22:0]});
        num = ma << 23;
        if (ma < mb) begin
            num = ma << 24;
            e   = e - 1;
        end
        q = num / mb;
        r = num % mb;
        if ((2 * r > mb) || ((2 * r == mb) && q[0])) q = q + 1;
        if (q == (longint'(1) << 24)) begin
            q = longint'(1) << 23;
            e = e + 1;
        end
        if (e >= 255) return {4'b0010, sg, 8'hFF, 23'h0};
        if (e <= 0)   return {4'b0001, sg, 31'h0};
        return {4'b0000, sg, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        int unsigned cls;
        logic [7:0]  e;
        logic [22:0] f;
        cls = $urandom_range(0, 9);
        f   = 23'($urandom);
        case (cls)
            0: e = 8'h00;
            1: begin e = 8'hFF; f = '0; end
            2: e = 8'hFF;
            3: e = 8'($urandom_range(1, 20));
            4: e = 8'($urandom_range(235, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, f};
    endfunction

    // Issue one float32 operation, wait (bounded) for done, check the done pulse width.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat,
                          output logic [31:0] res, output logic [3:0] flg, output bit busy_ok);
        in1 = a; in2 = b; start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        busy_ok = 1'b1;
        lat     = 0;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        res = out;
        flg = {dz, inv, ovf, udf};
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic run_op_h(input logic [15:0] a, input logic [15:0] b, output int lat,
                            output logic [15:0] res, output logic [3:0] flg);
        h_in1 = a; h_in2 = b; h_start = 1'b1;
        @(posedge clk); #1;
        h_start = 1'b0;
        lat = 0;
        while (!h_done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = h_out;
        flg = {h_dz, h_inv, h_ovf, h_udf};
    endtask

    initial begin
        int          lat;
        int          done_cyc;
        int          extra;
        bit          busy_ok;
        logic [31:0] res, a, b, ov_out;
        logic [15:0] hres;
        logic [3:0]  flg;
        logic [35:0] exp_r;

        // Reset state
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_out", 64'(out), 64'd0);
        check("rst_flags", 64'({dz, inv, ovf, udf}), 64'd0);
        check("rst_h_out", 64'(h_out), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        for (int i = 0; i < 7; i++) begin
            run_op(DIR_A[i], DIR_B[i], lat, res, flg, busy_ok);
            check($sformatf("dir%0d_latency", i), 64'(lat), 64'd28);
            check($sformatf("dir%0d_out", i), 64'(res), 64'(DIR_O[i]));
            check($sformatf("dir%0d_flags", i), 64'(flg), 64'(DIR_F[i]));
            check($sformatf("dir%0d_busy", i), 64'(busy_ok), 64'd1);
        end

        // Random operands against the reference model
        for (int i = 0; i < 80; i++) begin
            a = rand_op();
            b = rand_op();
            exp_r = ref_div(a, b);
            run_op(a, b, lat, res, flg, busy_ok);
            check($sformatf("rnd%0d_latency", i), 64'(lat), 64'd28);
            check($sformatf("rnd%0d_out %h/%h", i, a, b), 64'(res), 64'(exp_r[31:0]));
            check($sformatf("rnd%0d_flags %h/%h", i, a, b), 64'(flg), 64'(exp_r[35:32]));
        end

        // Start while busy is ignored; start coincident with done is ignored
        in1 = 32'h41000000; in2 = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_cyc = 0; extra = 0; busy_ok = 1'b1; ov_out = '0;
        for (int c = 1; c <= 28; c++) begin
            if (c == 10) begin
                in1 = 32'h3F800000; in2 = 32'h40400000; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done && done_cyc == 0) begin
                done_cyc = c;
                ov_out   = out;
            end
            if (c < 28 && !busy) busy_ok = 1'b0;
        end
        check("overlap_done_cycle", 64'(done_cyc), 64'd28);
        check("overlap_out", 64'(ov_out), 64'h40800000);
        check("overlap_busy", 64'(busy_ok), 64'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_at_done_ignored", 64'(busy), 64'd0);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check("no_extra_done", 64'(extra), 64'd0);

        // Reset in the middle of an operation
        in1 = 32'h3F800000; in2 = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_out", 64'(out), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        #2;
        rst_n = 1'b1;
        in1 = 32'h41000000; in2 = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("accept_after_reset", 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("after_reset_latency", 64'(lat), 64'd28);
        check("after_reset_out", 64'(out), 64'h40800000);

        // Half-precision instance
        run_op_h(16'h4B80, 16'h4500, lat, hres, flg);
        check("half_latency", 64'(lat), 64'd15);
        check("half_out", 64'(hres), 64'h4200);
        check("half_flags", 64'(flg), 64'd0);
        @(posedge clk); #1;
        run_op_h(16'h3C00, 16'h4200, lat, hres, flg);
        check("half_third_latency", 64'(lat), 64'd15);
        check("half_third_out", 64'(hres), 64'h3555);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
